// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - pipeline memory stage to single-outstanding word bus bridge
//
// Parameters:
//   TIMEOUT_CYC  cycles waited in RESP without a response before error completion
// Ports:
//   clk, rst_n                      clock; asynchronous active-high reset (1 = reset)
//   pipe_req_i/we_i/addr_i/wdata_i  access request from the memory stage
//   pipe_stall_o                    freeze upstream while an access is in flight
//   pipe_done_o/err_o/rdata_o       one-cycle completion pulse, error, last read word
//   bus_req_o/we_o/addr_o/wdata_o   bus request, held stable until bus_gnt_i
//   bus_gnt_i                       request accepted
//   bus_rvalid_i/rdata_i/err_i      response (read data or write ack) and error
`timescale 1ns/1ps

module mem_bus_if #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_req_i,
    input  logic        pipe_we_i,
    input  logic [31:0] pipe_addr_i,
    input  logic [31:0] pipe_wdata_i,
    output logic        pipe_stall_o,
    output logic        pipe_done_o,
    output logic [31:0] pipe_rdata_o,
    output logic        pipe_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          hold_we;
    logic [31:0]   hold_addr;
    logic [31:0]   hold_wdata;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] tmo_cnt;
    logic          resp_cap;
    logic          tmo_hit;

    // Byte-lane bits are dropped: the bus only sees word addresses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pipe_addr_i[1:0];

    always_comb begin
        state_nxt = state;
        resp_cap  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pipe_req_i) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // A response arriving with the grant completes the access at once;
                // rvalid without a grant belongs to nobody and is dropped.
                if (bus_gnt_i) begin
                    if (bus_rvalid_i) begin
                        state_nxt = S_DONE;
                        resp_cap  = 1'b1;
                    end else begin
                        state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus_rvalid_i) begin
                    state_nxt = S_DONE;
                    resp_cap  = 1'b1;
                end else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    // This is the TIMEOUT_CYC-th silent RESP cycle.
                    state_nxt = S_DONE;
                    tmo_hit   = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= S_IDLE;
            hold_we    <= 1'b0;
            hold_addr  <= 32'h0;
            hold_wdata <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && pipe_req_i) begin
                hold_we    <= pipe_we_i;
                hold_addr  <= {pipe_addr_i[31:2], 2'b00};
                hold_wdata <= pipe_wdata_i;
            end
            if (resp_cap) begin
                err_q <= bus_err_i;
                if (!hold_we) begin
                    rdata_q <= bus_rdata_i;
                end
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
            if (state == S_RESP && state_nxt == S_RESP) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign bus_req_o    = (state == S_REQ);
    assign bus_we_o     = (state == S_REQ) && hold_we;
    assign bus_addr_o   = hold_addr;
    assign bus_wdata_o  = hold_wdata;
    assign pipe_done_o  = (state == S_DONE);
    assign pipe_err_o   = (state == S_DONE) && err_q;
    assign pipe_rdata_o = rdata_q;
    assign pipe_stall_o = (state == S_IDLE && pipe_req_i) || state == S_REQ || state == S_RESP;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb/tb_mem_bus_if.sv - randomized scoreboard bench for mem_bus_if
`timescale 1ns/1ps

module tb_mem_bus_if;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pipe_req_i = 1'b0;
    logic        pipe_we_i = 1'b0;
    logic [31:0] pipe_addr_i = 32'h0;
    logic [31:0] pipe_wdata_i = 32'h0;
    logic        pipe_stall_o;
    logic        pipe_done_o;
    logic [31:0] pipe_rdata_o;
    logic        pipe_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'h0;
    logic        bus_err_i = 1'b0;

    mem_bus_if #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_req_i(pipe_req_i), .pipe_we_i(pipe_we_i),
        .pipe_addr_i(pipe_addr_i), .pipe_wdata_i(pipe_wdata_i),
        .pipe_stall_o(pipe_stall_o), .pipe_done_o(pipe_done_o),
        .pipe_rdata_o(pipe_rdata_o), .pipe_err_o(pipe_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } done_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    done_exp_t   done_q[$];
    bus_exp_t    bus_q[$];
    logic [31:0] model_rdata = 32'h0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a completion or a bus request.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            prev_done = 1'b0;
        end else begin
            if (!pipe_done_o) begin
                check("err_without_done", {31'h0, pipe_err_o}, 32'h0);
            end else begin
                check("done_single_cycle", {31'h0, prev_done}, 32'h0);
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    done_exp_t e;
                    e = done_q.pop_front();
                    check("done_err", {31'h0, pipe_err_o}, {31'h0, e.err});
                    check("done_rdata", pipe_rdata_o, e.rdata);
                end
            end
            prev_done = pipe_done_o;
            if (bus_req_o) begin
                if (bus_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_bus_req: got bus_req=1 expected 0");
                end else begin
                    check("bus_addr", bus_addr_o, bus_q[0].addr);
                    check("bus_we", {31'h0, bus_we_o}, {31'h0, bus_q[0].we});
                    check("bus_wdata", bus_wdata_o, bus_q[0].wdata);
                    if (bus_gnt_i) begin
                        void'(bus_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic scramble_pipe();
        pipe_req_i   = 1'($urandom_range(0, 1));
        pipe_we_i    = 1'($urandom_range(0, 1));
        pipe_addr_i  = $urandom;
        pipe_wdata_i = $urandom;
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_exp_t b;
        pipe_req_i   = 1'b1;
        pipe_we_i    = we;
        pipe_addr_i  = addr;
        pipe_wdata_i = wdata;
        b.we    = we;
        b.addr  = addr - (addr % 4);
        b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    task automatic push_done(input logic we, input bit tmo, input logic [31:0] rdat, input logic rerr);
        done_exp_t e;
        if (tmo) begin
            e.err = 1'b1;
        end else begin
            e.err = rerr;
            if (!we) model_rdata = rdat;
        end
        e.rdata = model_rdata;
        done_q.push_back(e);
    endtask

    // Plays the bus side of one access; returns with the DUT showing its completion pulse.
    task automatic run_bus(input logic we, input int exp_iters, input int gdly, input bit direct,
                           input int rdly, input bit tmo, input logic [31:0] rdat, input logic rerr);
        int it = 0;
        do begin
            @(posedge clk); #1;
            it++;
        end while (!bus_req_o && it < 6);
        check("accept_latency", it, exp_iters);
        if (!bus_req_o) return;
        for (int i = 0; i < gdly; i++) begin
            check("stall_req", {31'h0, pipe_stall_o}, 32'h1);
            scramble_pipe();
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'($urandom_range(0, 1));
            bus_rdata_i  = $urandom;
            bus_err_i    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("stall_gnt", {31'h0, pipe_stall_o}, 32'h1);
        scramble_pipe();
        bus_gnt_i = 1'b1;
        if (direct && !tmo) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rdat;
            bus_err_i    = rerr;
            push_done(we, 1'b0, rdat, rerr);
        end else begin
            bus_rvalid_i = 1'b0;
            @(posedge clk); #1;
            bus_gnt_i = 1'b0;
            for (int i = 0; i < (tmo ? TMO - 1 : rdly); i++) begin
                check("stall_resp", {31'h0, pipe_stall_o}, 32'h1);
                check("bus_req_in_resp", {31'h0, bus_req_o}, 32'h0);
                scramble_pipe();
                bus_gnt_i   = 1'($urandom_range(0, 1));
                bus_rdata_i = $urandom;
                @(posedge clk); #1;
            end
            check("stall_resp_last", {31'h0, pipe_stall_o}, 32'h1);
            if (tmo) begin
                push_done(we, 1'b1, rdat, rerr);
            end else begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = rdat;
                bus_err_i    = rerr;
                push_done(we, 1'b0, rdat, rerr);
            end
        end
        @(posedge clk); #1;
        pipe_req_i   = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'($urandom_range(0, 1));
        bus_rdata_i  = $urandom;
        check("done_pulse", {31'h0, pipe_done_o}, 32'h1);
        check("stall_in_done", {31'h0, pipe_stall_o}, 32'h0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        pipe_req_i   = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'($urandom_range(0, 1));
        bus_rdata_i  = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, {31'h0, bus_req_o}, 32'h0);
        check({tag, "_bus_we"}, {31'h0, bus_we_o}, 32'h0);
        check({tag, "_done"}, {31'h0, pipe_done_o}, 32'h0);
        check({tag, "_err"}, {31'h0, pipe_err_o}, 32'h0);
        check({tag, "_stall"}, {31'h0, pipe_stall_o}, 32'h0);
        check({tag, "_bus_addr"}, bus_addr_o, 32'h0);
        check({tag, "_bus_wdata"}, bus_wdata_o, 32'h0);
        check({tag, "_rdata"}, pipe_rdata_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_cycle();

        // Read with unaligned address, response two cycles after grant.
        start_req(1'b0, 32'h0000_1006, $urandom);
        run_bus(1'b0, 1, 0, 1'b0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        check("read_rdata", pipe_rdata_o, 32'hDEAD_BEEF);
        check("read_err", {31'h0, pipe_err_o}, 32'h0);
        idle_cycle();

        // Write with grant delayed three cycles and same-cycle ack.
        start_req(1'b1, 32'h0000_0020, 32'h1234_5678);
        run_bus(1'b1, 1, 3, 1'b1, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
        check("write_keeps_rdata", pipe_rdata_o, 32'hDEAD_BEEF);
        idle_cycle();

        // Read that never gets a response.
        start_req(1'b0, 32'h0000_0040, 32'h0);
        run_bus(1'b0, 1, 0, 1'b0, 0, 1'b1, 32'h0, 1'b0);
        check("timeout_err", {31'h0, pipe_err_o}, 32'h1);
        idle_cycle();
        check("timeout_then_idle", {31'h0, pipe_done_o}, 32'h0);

        // Read with bus error.
        start_req(1'b0, 32'h0000_0080, 32'h0);
        run_bus(1'b0, 1, 1, 1'b0, 0, 1'b0, 32'h5555_AAAA, 1'b1);
        check("bus_err", {31'h0, pipe_err_o}, 32'h1);
        idle_cycle();

        // Minimum latency read, then a request held through DONE.
        start_req(1'b0, 32'h0000_0100, 32'h0);
        run_bus(1'b0, 1, 0, 1'b1, 0, 1'b0, 32'h0BAD_F00D, 1'b0);
        start_req(1'b1, 32'h0000_0104, 32'h7777_8888);
        run_bus(1'b1, 2, 2, 1'b0, 2, 1'b0, 32'h0, 1'b0);
        idle_cycle();

        // Reset pulsed during RESP abandons the access.
        start_req(1'b0, 32'h0000_0200, 32'h0);
        @(posedge clk); #1;
        pipe_req_i = 1'b0;
        bus_gnt_i  = 1'b1;
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check_all_zero("mid_reset");
        model_rdata = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_cycle();
        idle_cycle();
        start_req(1'b0, 32'h0000_0300, 32'h0);
        run_bus(1'b0, 1, 0, 1'b0, 0, 1'b0, 32'h1357_9BDF, 1'b0);
        check("after_reset_rdata", pipe_rdata_o, 32'h1357_9BDF);
        idle_cycle();

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic        we;
            bit          b2b;
            we  = 1'($urandom_range(0, 1));
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) begin
                for (int k = 0; k <= int'($urandom_range(0, 2)); k++) idle_cycle();
            end
            start_req(we, $urandom, $urandom);
            run_bus(we, b2b ? 2 : 1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), $urandom,
                    ($urandom_range(0, 3) == 0));
        end
        idle_cycle();
        idle_cycle();
        check("done_queue_empty", done_q.size(), 32'h0);
        check("bus_queue_empty", bus_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
